// File: rtl/fake_netlist_pkg.sv
`default_nettype none
// ============================================================================
// fake_netlist_pkg
// Shared constants and the stage-1 payload type of the cone pipeline.
// Revision: 1.0
// ============================================================================
package fake_netlist_pkg;

  localparam int CONE_INPUTS = 14;

  // Everything the second half of a lane cone needs after the first register.
  typedef struct packed {
    logic b;
    logic n2;
    logic n3;
    logic n4;
    logic n5;
    logic n7;
    logic n9;
    logic n10;
    logic n11;
  } s1_lane_t;

endpackage
`default_nettype wire

// File: rtl/fake_netlist_cone_lane.sv
`default_nettype none
// ============================================================================
// fake_netlist_cone_lane
// One lane of the logic cone, split into the pre-S1 and post-S1 halves.
// Revision: 1.0
// ============================================================================
module fake_netlist_cone_lane
  import fake_netlist_pkg::*;
(
  input  logic [CONE_INPUTS-1:0] n_i,
  output s1_lane_t               s1_o,
  input  s1_lane_t               s1_i,
  output logic                   res_o
);

  logic a;
  logic c;
  logic d;

  always_comb begin
    a        = (n_i[8] & ~n_i[0]) | (~n_i[6] & ~n_i[12]);
    s1_o.b   = ~a & (~n_i[13] | n_i[1]);
    s1_o.n2  = n_i[2];
    s1_o.n3  = n_i[3];
    s1_o.n4  = n_i[4];
    s1_o.n5  = n_i[5];
    s1_o.n7  = n_i[7];
    s1_o.n9  = n_i[9];
    s1_o.n10 = n_i[10];
    s1_o.n11 = n_i[11];
  end

  always_comb begin
    c     = (s1_i.b & s1_i.n9) | (s1_i.n3 & s1_i.n4);
    d     = ~((c & s1_i.n2) | s1_i.n5);
    res_o = ~((d & s1_i.n7) | (s1_i.n10 & s1_i.n11));
  end

endmodule
`default_nettype wire

// File: rtl/fake_netlist_pipe.sv
`default_nettype none
// ============================================================================
// fake_netlist_pipe
// Two-stage multi-lane cone pipeline feeding a credit-controlled output FIFO.
// Revision: 1.0
// ============================================================================
module fake_netlist_pipe
  import fake_netlist_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CONE_INPUTS*LANES-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_data,
  output logic [CNT_W-1:0]             result_cnt,
  input  logic                         clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [PW:0]      PTR_ONE = (PW + 1)'(1);
  localparam logic [OW-1:0]    OCC_ONE = OW'(1);
  localparam logic [OW-1:0]    OCC_MAX = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   in_fire;
  logic                   out_fire;
  s1_lane_t [LANES-1:0]   s1_d;
  s1_lane_t [LANES-1:0]   s1_q;
  logic                   s1_vld_q;
  logic [LANES-1:0]       s2_d;
  logic [LANES-1:0]       s2_q;
  logic                   s2_vld_q;
  logic [LANES-1:0]       mem_q [DEPTH];
  logic [PW:0]            wptr_q;
  logic [PW:0]            rptr_q;
  logic [OW-1:0]          occ_d;
  logic [OW-1:0]          occ_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       cnt_q;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      fake_netlist_cone_lane u_lane (
        .n_i   (in_data[CONE_INPUTS*l +: CONE_INPUTS]),
        .s1_o  (s1_d[l]),
        .s1_i  (s1_q[l]),
        .res_o (s2_d[l])
      );
    end
  endgenerate

  // Credits cover S1, S2 and the FIFO, so the FIFO can never overflow.
  assign in_ready   = rst_n & (occ_q < OCC_MAX);
  assign in_fire    = in_valid & in_ready;
  assign out_valid  = (wptr_q != rptr_q);
  assign out_fire   = out_valid & out_ready;
  assign out_data   = mem_q[rptr_q[PW-1:0]];
  assign result_cnt = cnt_q;

  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = out_fire ? CNT_ONE : '0;
    end else if (out_fire) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= in_fire;
      s2_vld_q <= s1_vld_q;
      if (s2_vld_q) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (out_fire) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_q <= s1_d;
    end
    if (s1_vld_q) begin
      s2_q <= s2_d;
    end
    if (s2_vld_q) begin
      mem_q[wptr_q[PW-1:0]] <= s2_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fake_netlist_pipe.sv
`default_nettype none
// ============================================================================
// tb_fake_netlist_pipe
// Self-checking bench against a transaction-level model of the cone pipeline.
// Revision: 1.0
// ============================================================================
module tb_fake_netlist_pipe;

  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int DW    = 14 * LANES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LANES-1:0] out_data;
  logic [CNT_W-1:0] result_cnt;
  logic             clr = 1'b0;

  fake_netlist_pipe #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .result_cnt (result_cnt),
    .clr        (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] res;
    int               rdy;
  } item_t;

  item_t            q[$];
  int               cyc = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  int               checks = 0;
  int               errors = 0;
  logic             last_pop = 1'b0;

  function automatic logic cone(input logic [13:0] n);
    logic a, b, c, d;
    a = (n[8] & ~n[0]) | (~n[6] & ~n[12]);
    b = ~a & (~n[13] | n[1]);
    c = (b & n[9]) | (n[3] & n[4]);
    d = ~((c & n[2]) | n[5]);
    return ~((d & n[7]) | (n[10] & n[11]));
  endfunction

  function automatic logic [LANES-1:0] ref_vec(input logic [DW-1:0] v);
    logic [LANES-1:0] r;
    for (int l = 0; l < LANES; l++) r[l] = cone(v[14*l +: 14]);
    return r;
  endfunction

  function automatic logic exp_valid();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Drive one cycle, advance the model, and land 1 time unit after the edge.
  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic c);
    logic  acc, pop;
    item_t it;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    acc = iv && (q.size() < DEPTH);
    pop = exp_valid() && ordy;
    if (pop) void'(q.pop_front());
    if (c) cnt_m = pop ? CNT_W'(1) : '0;
    else if (pop) cnt_m = cnt_m + CNT_W'(1);
    if (acc) begin
      it.res = ref_vec(d);
      it.rdy = cyc + 3;
      q.push_back(it);
    end
    last_pop = pop;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && q.size() > 0; t++) tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (result_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", result_cnt); end
    rst_n = 1'b1;
    q.delete();
    cnt_m = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid: got %b expected 0", out_valid); end
  endtask

  // Lane 0 carries the fixed patterns; accepted on the first edge, visible two edges later.
  task automatic test_latency();
    logic [13:0]   pat [4];
    logic [DW-1:0] d;
    logic          ev;
    pat = '{14'h0000, 14'h0080, 14'h0284, 14'h0C00};
    for (int t = 0; t < 7; t++) begin
      d = rnd_vec();
      if (t < 4) d[13:0] = pat[t];
      tick(t < 4, d, 1'b1, 1'b0);
      ev = (t >= 2) && (t <= 5);
      checks++;
      if (out_valid !== ev) begin
        errors++; $display("FAIL lat_valid[%0d]: got %b expected %b", t, out_valid, ev);
      end else if (ev) begin
        checks++;
        if (out_data[0] !== cone(pat[t-2])) begin
          errors++; $display("FAIL lat_data[%0d]: got %b expected %b", t, out_data[0], cone(pat[t-2]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc_dut;
    int n;
    acc_dut = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready === 1'b1) acc_dut++;
      tick(1'b1, rnd_vec(), 1'b0, 1'b0);
      checks++;
      if (in_ready !== (i < 3)) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, i < 3); end
    end
    checks++; if (acc_dut != DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d expected %0d", acc_dut, DEPTH); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== q[0].res) begin
      errors++; $display("FAIL bp_head: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, q[0].res);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_credit_back: got %b expected 1", in_ready); end
    n = 0;
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      if (exp_valid()) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== q[0].res) begin
          errors++; $display("FAIL bp_order[%0d]: got v=%b d=%h expected v=1 d=%h", n, out_valid, out_data, q[0].res);
        end
        n++;
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (n != DEPTH - 1) begin errors++; $display("FAIL bp_drain: got %0d expected %0d", n, DEPTH - 1); end
  endtask

  task automatic test_lanes();
    logic [DW-1:0] d;
    d = {14'h0C00, 14'h0284, 14'h0080, 14'h0000};
    tick(1'b1, d, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_vec(d)) begin
      errors++; $display("FAIL lanes: got v=%b d=%b expected v=1 d=%b", out_valid, out_data, ref_vec(d));
    end
    drain();
  endtask

  task automatic test_counter();
    int pops;
    drain();
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (result_cnt !== '0) begin errors++; $display("FAIL cnt_clr: got %0d expected 0", result_cnt); end
    pops = 0;
    for (int t = 0; t < 200 && pops < 17; t++) begin
      tick(1'b1, rnd_vec(), 1'b1, 1'b0);
      if (last_pop) pops++;
    end
    checks++; if (pops != 17) begin errors++; $display("FAIL cnt_pops: got %0d expected 17", pops); end
    checks++; if (result_cnt !== CNT_W'(1)) begin errors++; $display("FAIL cnt_wrap: got %0d expected 1", result_cnt); end
    for (int t = 0; t < 10 && !exp_valid(); t++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b1);
    checks++; if (last_pop !== 1'b1) begin errors++; $display("FAIL cnt_clr_hs_pop: got %b expected 1", last_pop); end
    checks++; if (result_cnt !== CNT_W'(1)) begin errors++; $display("FAIL cnt_clr_hs: got %0d expected 1", result_cnt); end
  endtask

  task automatic test_reset_inflight();
    drain();
    for (int i = 0; i < 3; i++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rif_out_valid: got %b expected 0", out_valid); end
    checks++; if (result_cnt !== '0) begin errors++; $display("FAIL rif_cnt: got %0d expected 0", result_cnt); end
    checks++; if (dut.occ_q !== '0) begin errors++; $display("FAIL rif_occ: got %0d expected 0", dut.occ_q); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    cnt_m = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rif_in_ready: got %b expected 1", in_ready); end
    for (int t = 0; t < 6; t++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rif_stale[%0d]: got %b expected 0", t, out_valid); end
    end
  endtask

  task automatic test_random();
    int   rdy_pct;
    logic iv, ordy, c;
    rdy_pct = 70;
    for (int t = 0; t < 10000; t++) begin
      if (t % 500 == 0) rdy_pct = $urandom_range(10, 95);
      checks++;
      if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", t, in_ready, q.size() < DEPTH); end
      checks++;
      if (out_valid !== exp_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", t, out_valid, exp_valid()); end
      if (exp_valid()) begin
        checks++;
        if (out_data !== q[0].res) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", t, out_data, q[0].res); end
      end
      checks++;
      if (result_cnt !== cnt_m) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", t, result_cnt, cnt_m); end
      checks++;
      if (dut.occ_q > DEPTH) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d expected <= %0d", t, dut.occ_q, DEPTH); end
      iv   = ($urandom_range(0, 99) < 75);
      ordy = ($urandom_range(0, 99) < rdy_pct);
      c    = ($urandom_range(0, 63) == 0);
      tick(iv, rnd_vec(), ordy, c);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_lanes();
    test_counter();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
